// File: rtl/aes_sbox_array.sv
// Multi-lane masked AES S-box: NumStages-deep pipeline, one transaction per cycle,
// whole pipeline holds while the output is stalled; PRD register rotates per accept.
module aes_sbox_array #(
  parameter int NumLanes  = 4,
  parameter int NumStages = 2,
  parameter int CntWidth  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic [8*NumLanes-1:0] data_i,
  input  logic [8*NumLanes-1:0] mask_i,
  input  logic                  prd_we_i,
  input  logic [8*NumLanes-1:0] prd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [8*NumLanes-1:0] data_o,
  output logic [8*NumLanes-1:0] mask_o,
  output logic [CntWidth-1:0]   txn_cnt_o,
  output logic                  err_o
);

  localparam int W = 8 * NumLanes;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  logic [NumStages-1:0]        vld_q, vld_d;
  logic [NumStages-1:0][W-1:0] data_q, data_d;
  logic [NumStages-1:0][W-1:0] mask_q, mask_d;
  logic [W-1:0]                prd_q, prd_d;
  logic [CntWidth-1:0]         cnt_q, cnt_d;
  logic                        err_q, err_d;

  logic         stall;
  logic         accept;
  logic         out_hs;
  logic         inv_op;
  logic         bad_op;
  logic [W-1:0] sub_res;

  always_comb begin
    logic [7:0] x;
    x       = 8'h00;
    stall   = vld_q[NumStages-1] && !out_ready_i;
    in_ready_o = !stall && !clear_i;
    accept  = in_valid_i && in_ready_o;
    out_hs  = vld_q[NumStages-1] && out_ready_i;
    inv_op  = (op_i == 2'b10);
    bad_op  = (op_i != 2'b01) && (op_i != 2'b10);
    sub_res = '0;
    // Unmasked byte lives only on this combinational path; it is remasked before any flop.
    for (int l = 0; l < NumLanes; l++) begin
      x = data_i[8*l +: 8] ^ mask_i[8*l +: 8];
      sub_res[8*l +: 8] = (inv_op ? sbox_inv(x) : sbox_fwd(x)) ^ prd_q[8*l +: 8];
    end
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    mask_d = mask_q;
    if (clear_i) begin
      vld_d = '0;
    end else if (!stall) begin
      // Payload only moves with a valid beat so data_o/mask_o hold across bubbles.
      vld_d[0] = accept;
      if (accept) begin
        data_d[0] = sub_res;
        mask_d[0] = prd_q;
      end
      for (int s = 1; s < NumStages; s++) begin
        vld_d[s] = vld_q[s-1];
        if (vld_q[s-1]) begin
          data_d[s] = data_q[s-1];
          mask_d[s] = mask_q[s-1];
        end
      end
    end
  end

  always_comb begin
    prd_d = prd_q;
    if (prd_we_i)    prd_d = prd_i;
    else if (accept) prd_d = {prd_q[W-2:0], prd_q[W-1]};
    cnt_d = cnt_q + CntWidth'(out_hs);
    err_d = err_q | (accept && bad_op);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      data_q <= '0;
      mask_q <= '0;
      prd_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      mask_q <= mask_d;
      prd_q  <= prd_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign out_valid_o = vld_q[NumStages-1];
  assign data_o      = data_q[NumStages-1];
  assign mask_o      = mask_q[NumStages-1];
  assign txn_cnt_o   = cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_aes_sbox_array.sv
// Directed bench for aes_sbox_array (4 lanes, 2 stages): hand-computed S-box vectors.
module tb_aes_sbox_array;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready, prd_we, out_valid, out_ready, err;
  logic [1:0]  op;
  logic [31:0] din, min, prd, dout, mout;
  logic [15:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_sbox_array #(.NumLanes(4), .NumStages(2), .CntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
    .data_i(din), .mask_i(min), .prd_we_i(prd_we), .prd_i(prd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(dout), .mask_o(mout), .txn_cnt_o(cnt), .err_o(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prd(input logic [31:0] v);
    prd_we = 1'b1; prd = v;
    tick();
    prd_we = 1'b0;
  endtask

  // Stimulus only: accepts one transaction, waits (bounded) for its output, consumes it.
  task automatic run_one(input logic [1:0] o, input logic [31:0] d, input logic [31:0] m,
                         output int lat, output logic [31:0] rd, output logic [31:0] rm);
    in_valid = 1'b1; op = o; din = d; min = m;
    tick();
    in_valid = 1'b0; prd_we = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    rd = dout; rm = mout;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_vec++; if (dout !== 32'h0) begin n_err++; $display("FAIL rst_data got %h want 0", dout); end
    n_vec++; if (mout !== 32'h0) begin n_err++; $display("FAIL rst_mask got %h want 0", mout); end
    n_vec++; if (cnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt got %h want 0", cnt); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", err); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", in_ready); end
  endtask

  task automatic test_forward();
    int lat;
    logic [31:0] rd, rm;
    load_prd(32'h3C3C3C3C);
    run_one(2'b01, 32'h09090909, 32'h5A5A5A5A, lat, rd, rm);
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL fwd_latency got %0d want 2", lat); end
    n_vec++; if (rd !== 32'hD1D1D1D1) begin n_err++; $display("FAIL fwd_data got %h want d1d1d1d1", rd); end
    n_vec++; if (rm !== 32'h3C3C3C3C) begin n_err++; $display("FAIL fwd_mask got %h want 3c3c3c3c", rm); end
    n_vec++; if (cnt !== 16'd1) begin n_err++; $display("FAIL fwd_cnt got %0d want 1", cnt); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fwd_idle_valid got %b want 0", out_valid); end
    n_vec++; if (dout !== 32'hD1D1D1D1) begin n_err++; $display("FAIL fwd_hold got %h want d1d1d1d1", dout); end
    // Mixed lanes: x = 00,01,FF,63 -> 63,7C,16,FB, remasked with P lanes 04,03,02,01.
    load_prd(32'h01020304);
    run_one(2'b01, 32'h27CC2311, 32'h44332211, lat, rd, rm);
    n_vec++; if (rd !== 32'hFA147F67) begin n_err++; $display("FAIL fwd_mixed_data got %h want fa147f67", rd); end
    n_vec++; if (rm !== 32'h01020304) begin n_err++; $display("FAIL fwd_mixed_mask got %h want 01020304", rm); end
  endtask

  task automatic test_inverse();
    int lat;
    logic [31:0] rd, rm;
    load_prd(32'h0);
    run_one(2'b10, 32'h167CED63, 32'h0, lat, rd, rm);
    n_vec++; if (rd !== 32'hFF015300) begin n_err++; $display("FAIL inv_data got %h want ff015300", rd); end
    n_vec++; if (rm !== 32'h0) begin n_err++; $display("FAIL inv_mask got %h want 0", rm); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL inv_err got %b want 0", err); end
  endtask

  task automatic test_prd_collision();
    int lat;
    logic [31:0] rd, rm;
    load_prd(32'h00000001);
    prd_we = 1'b1; prd = 32'hAAAAAAAA;
    run_one(2'b01, 32'h0, 32'h0, lat, rd, rm);
    n_vec++; if (rm !== 32'h00000001) begin n_err++; $display("FAIL prd_old_mask got %h want 00000001", rm); end
    n_vec++; if (rd !== 32'h63636362) begin n_err++; $display("FAIL prd_old_data got %h want 63636362", rd); end
    run_one(2'b01, 32'h0, 32'h0, lat, rd, rm);
    n_vec++; if (rm !== 32'hAAAAAAAA) begin n_err++; $display("FAIL prd_new_mask got %h want aaaaaaaa", rm); end
    n_vec++; if (rd !== 32'hC9C9C9C9) begin n_err++; $display("FAIL prd_new_data got %h want c9c9c9c9", rd); end
    run_one(2'b01, 32'h0, 32'h0, lat, rd, rm);
    n_vec++; if (rm !== 32'h55555555) begin n_err++; $display("FAIL prd_rot_mask got %h want 55555555", rm); end
    n_vec++; if (rd !== 32'h36363636) begin n_err++; $display("FAIL prd_rot_data got %h want 36363636", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [5];
    logic [31:0] exps [5];
    logic [15:0] cnt_exp;
    int ii, no, stall_left, cyc;
    logic stalling, acc, hs;
    ins  = '{32'h00000000, 32'h01010101, 32'hFFFFFFFF, 32'h63636363, 32'h53535353};
    exps = '{32'h63636363, 32'h7C7C7C7C, 32'h16161616, 32'hFBFBFBFB, 32'hEDEDEDED};
    load_prd(32'h0);
    cnt_exp = cnt + 16'd5;
    ii = 0; no = 0; stall_left = 3; cyc = 0;
    while (no < 5 && cyc < 40) begin
      in_valid = (ii < 5); op = 2'b01; min = 32'h0;
      din = (ii < 5) ? ins[ii] : 32'h0;
      stalling = out_valid && (no == 1) && (stall_left > 0);
      out_ready = !stalling;
      if (stalling) stall_left--;
      #1;
      if (stalling) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_ready got %b want 0", in_ready); end
      end
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        n_vec++; if (dout !== exps[no]) begin n_err++; $display("FAIL b2b_data%0d got %h want %h", no, dout, exps[no]); end
      end
      tick();
      if (acc) ii++;
      if (hs) no++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (no != 5) begin n_err++; $display("FAIL b2b_outputs got %0d want 5", no); end
    n_vec++; if (stall_left != 0) begin n_err++; $display("FAIL b2b_stall_cycles left %0d want 0", stall_left); end
    n_vec++; if (cnt !== cnt_exp) begin n_err++; $display("FAIL b2b_cnt got %0d want %0d", cnt, cnt_exp); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained got %b want 0", out_valid); end
  endtask

  task automatic test_err();
    in_valid = 1'b1; op = 2'b11; din = 32'h53535353; min = 32'h0;
    #1;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_before got %b want 0", err); end
    tick();
    in_valid = 1'b0; op = 2'b01;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_set got %b want 1", err); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || dout !== 32'hEDEDEDED) begin
      n_err++; $display("FAIL err_fwd_result got v=%b %h want v=1 edededed", out_valid, dout);
    end
    tick();
    clear = 1'b1; tick(); clear = 1'b0;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_after_clear got %b want 1", err); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_after_rst got %b want 0", err); end
  endtask

  task automatic test_flush();
    int lat;
    logic [31:0] rd, rm;
    logic [15:0] cnt0;
    logic seen;
    load_prd(32'h12345678);
    cnt0 = cnt;
    in_valid = 1'b1; op = 2'b01; din = 32'h0; min = 32'h0;
    tick(); tick();
    clear = 1'b1; out_ready = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready got %b want 0", in_ready); end
    tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clr_valid got %b want 0", out_valid); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen = seen | out_valid; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL clr_ghost got %b want 0", seen); end
    n_vec++; if (cnt !== cnt0) begin n_err++; $display("FAIL clr_cnt got %0d want %0d", cnt, cnt0); end
    run_one(2'b01, 32'h0, 32'h0, lat, rd, rm);
    n_vec++; if (rm !== 32'h48D159E0) begin n_err++; $display("FAIL clr_prd_kept got %h want 48d159e0", rm); end
    n_vec++; if (rd !== 32'h2BB23A83) begin n_err++; $display("FAIL clr_data got %h want 2bb23a83", rd); end

    load_prd(32'hAAAAAAAA);
    in_valid = 1'b1; op = 2'b01; din = 32'h0; min = 32'h0;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || dout !== 32'h0 || mout !== 32'h0) begin
      n_err++; $display("FAIL rst_flush_out got v=%b d=%h m=%h want 0 0 0", out_valid, dout, mout);
    end
    n_vec++; if (cnt !== 16'h0 || err !== 1'b0) begin
      n_err++; $display("FAIL rst_flush_state got cnt=%0d err=%b want 0 0", cnt, err);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen = seen | out_valid; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_ghost got %b want 0", seen); end
    run_one(2'b01, 32'h0, 32'h0, lat, rd, rm);
    n_vec++; if (rm !== 32'h0 || rd !== 32'h63636363) begin
      n_err++; $display("FAIL rst_prd_zero got d=%h m=%h want 63636363 0", rd, rm);
    end
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; op = 2'b01; din = '0; min = '0;
    prd_we = 1'b0; prd = '0; out_ready = 1'b1;
    test_reset();
    test_forward();
    test_inverse();
    test_prd_collision();
    test_back_to_back();
    test_err();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
